// File: rtl/spi_slave_regbank.sv
// SPI mode-0 target with a bank of 8-bit registers.
// SCK, MOSI and CSN are oversampled on clk. A command byte selects read or
// write and the start address. The following data bytes auto-increment the address.
// Register 0 is a read-only ID. Registers are exposed flattened on regs_o.
module spi_slave_regbank #(
    parameter int         NREGS  = 16,
    parameter int         ADDR_W = 4,
    parameter logic [7:0] ID_VAL = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    input  logic                  spi_csn,
    output logic                  spi_miso,
    output logic                  spi_misooen,
    output logic [NREGS*8-1:0]    regs_o,
    output logic                  wr_pulse,
    output logic [ADDR_W-1:0]     wr_addr_o,
    output logic                  rd_pulse,
    output logic                  frame_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_WDATA = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    // Synchroniser stages plus delayed copies for edge detection
    logic r_sck_s1, r_sck_s2, r_sck_d;
    logic r_mosi_s1, r_mosi_s2;
    logic r_csn_s1, r_csn_s2, r_csn_d;

    state_t            r_state;
    logic [2:0]        r_bit_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [6:0]        r_shift_in;
    logic [7:0]        r_shift_out;
    logic              r_miso;
    logic              r_misooen;
    logic              r_wr_pulse;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_rd_pulse;
    logic              r_frame_err;

    logic              w_sck_rise;
    logic              w_sck_fall;
    logic              w_csn_rise;
    logic              w_csn_fall;
    logic [7:0]        w_byte_in;
    logic [7:0]        w_rd_byte;
    logic              w_wr_en;

    // Two-flop synchronisers for the asynchronous SPI pins.
    // CSN resets to the asserted level so that a CSN still held low when
    // reset is released does not look like a frame start; a new frame then
    // needs CSN to go high and fall again.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_d   <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_csn_s1  <= 1'b0;
            r_csn_s2  <= 1'b0;
            r_csn_d   <= 1'b0;
        end else begin
            r_sck_s1  <= spi_sck;
            r_sck_s2  <= r_sck_s1;
            r_sck_d   <= r_sck_s2;
            r_mosi_s1 <= spi_mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_csn_s1  <= spi_csn;
            r_csn_s2  <= r_csn_s1;
            r_csn_d   <= r_csn_s2;
        end
    end

    // SCK edges only count while the synchronised chip select is low
    assign w_sck_rise = r_sck_s2 & ~r_sck_d & ~r_csn_s2;
    assign w_sck_fall = ~r_sck_s2 & r_sck_d & ~r_csn_s2;
    assign w_csn_rise = r_csn_s2 & ~r_csn_d;
    assign w_csn_fall = ~r_csn_s2 & r_csn_d;

    // Byte as it stands after shifting in the current MOSI sample
    assign w_byte_in = {r_shift_in, r_mosi_s2};

    // Last bit of a data byte in a write frame commits the register
    assign w_wr_en = (r_state == S_WDATA) && w_sck_rise && (r_bit_cnt == 3'd7);

    // Readout mux; addresses beyond the implemented bank read as zero
    always_comb begin
        w_rd_byte = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            if (r_addr == ADDR_W'(i)) begin
                w_rd_byte = regs_o[i*8 +: 8];
            end
        end
    end

    // Frame FSM: command decode, bit counting, MISO shifting and strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_addr      <= '0;
            r_shift_in  <= 7'd0;
            r_shift_out <= 8'd0;
            r_miso      <= 1'b0;
            r_misooen   <= 1'b1;
            r_wr_pulse  <= 1'b0;
            r_wr_addr   <= '0;
            r_rd_pulse  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_pulse  <= 1'b0;
            r_rd_pulse  <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_state != S_IDLE && w_csn_rise) begin
                // End of frame; a partial byte is dropped and flagged
                r_state     <= S_IDLE;
                r_frame_err <= (r_bit_cnt != 3'd0);
                r_bit_cnt   <= 3'd0;
                r_miso      <= 1'b0;
                r_misooen   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_csn_fall) begin
                            r_state   <= S_CMD;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    S_CMD: begin
                        if (w_sck_rise) begin
                            r_shift_in <= w_byte_in[6:0];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_addr <= w_byte_in[ADDR_W-1:0];
                                if (w_byte_in[7]) begin
                                    r_state <= S_WDATA;
                                end else begin
                                    r_state   <= S_RDATA;
                                    r_misooen <= 1'b0;
                                end
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_sck_rise) begin
                            r_shift_in <= w_byte_in[6:0];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                // Strobe even when the address is read-only or unimplemented
                                r_wr_pulse <= 1'b1;
                                r_wr_addr  <= r_addr;
                                r_addr     <= r_addr + ADDR_W'(1);
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_sck_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end else if (w_sck_fall) begin
                            if (r_bit_cnt == 3'd0) begin
                                // Byte boundary: fetch the next register
                                r_miso      <= w_rd_byte[7];
                                r_shift_out <= {w_rd_byte[6:0], 1'b0};
                                r_rd_pulse  <= 1'b1;
                                r_addr      <= r_addr + ADDR_W'(1);
                            end else begin
                                r_miso      <= r_shift_out[7];
                                r_shift_out <= {r_shift_out[6:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Register 0 is a constant ID
    assign regs_o[7:0] = ID_VAL;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [7:0] r_reg;

            // Capture the completed data byte when this register is addressed
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_reg <= 8'h00;
                end else if (w_wr_en && (r_addr == ADDR_W'(gi))) begin
                    r_reg <= w_byte_in;
                end
            end

            assign regs_o[gi*8 +: 8] = r_reg;
        end
    endgenerate

    assign spi_miso    = r_miso;
    assign spi_misooen = r_misooen;
    assign wr_pulse    = r_wr_pulse;
    assign wr_addr_o   = r_wr_addr;
    assign rd_pulse    = r_rd_pulse;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Testbench for spi_slave_regbank: an SPI mode-0 master model drives frames.
// Expected writes and read bytes are queued when a frame is set up. They are
// checked when the DUT strobes wr_pulse or shifts a byte out on MISO.
module tb_spi_slave_regbank;

    localparam int NREGS  = 16;
    localparam int ADDR_W = 4;
    localparam int HALF   = 6;

    logic                  clk;
    logic                  rstn;
    logic                  spi_sck;
    logic                  spi_mosi;
    logic                  spi_csn;
    logic                  spi_miso;
    logic                  spi_misooen;
    logic [NREGS*8-1:0]    regs_o;
    logic                  wr_pulse;
    logic [ADDR_W-1:0]     wr_addr_o;
    logic                  rd_pulse;
    logic                  frame_err;

    typedef struct {
        logic [ADDR_W-1:0]  addr;
        logic [NREGS*8-1:0] img;
    } wr_exp_t;

    wr_exp_t     wr_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  model [NREGS];
    logic [7:0]  tx_buf [8];
    int          n_cmp;
    int          n_err;
    int          rd_cnt;
    int          fe_cnt;

    spi_slave_regbank #(
        .NREGS (NREGS),
        .ADDR_W(ADDR_W),
        .ID_VAL(8'hA5)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_csn    (spi_csn),
        .spi_miso   (spi_miso),
        .spi_misooen(spi_misooen),
        .regs_o     (regs_o),
        .wr_pulse   (wr_pulse),
        .wr_addr_o  (wr_addr_o),
        .rd_pulse   (rd_pulse),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NREGS*8-1:0] model_img();
        logic [NREGS*8-1:0] img;
        for (int i = 0; i < NREGS; i++) img[i*8 +: 8] = model[i];
        return img;
    endfunction

    task automatic model_reset();
        model[0] = 8'hA5;
        for (int i = 1; i < NREGS; i++) model[i] = 8'h00;
    endtask

    // Queue the write expected for one data byte and update the model
    task automatic push_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        wr_exp_t e;
        if (a != 0) model[a] = d;
        e.addr = a;
        e.img  = model_img();
        wr_q.push_back(e);
    endtask

    // Scoreboard side for writes, plus strobe counters
    always @(negedge clk) begin
        if (rstn) begin
            if (rd_pulse) rd_cnt++;
            if (frame_err) fe_cnt++;
            if (wr_pulse) begin
                n_cmp++;
                if (wr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL wr_unexpected: wr_pulse addr=%0d, no write expected", wr_addr_o);
                end else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    if (wr_addr_o !== e.addr || regs_o !== e.img) begin
                        n_err++;
                        $display("FAIL wr_check: addr=%0d regs=%h, expected addr=%0d regs=%h",
                                 wr_addr_o, regs_o, e.addr, e.img);
                    end else begin
                        $display("write addr=%0d data=%h", wr_addr_o, regs_o[e.addr*8 +: 8]);
                    end
                end
            end
        end
    end

    // One mode-0 bit: SCK falls, MOSI changes, MISO sampled before the rise
    task automatic spi_bit(input logic mo, output logic mi, output logic oe);
        spi_sck  = 1'b0;
        spi_mosi = mo;
        repeat (HALF) @(posedge clk);
        #1;
        mi = spi_miso;
        oe = spi_misooen;
        spi_sck = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    // Full frame from tx_buf: nbytes whole bytes plus tail_bits of the next.
    // CSN rises while SCK is still high after the last rise, so the closing
    // SCK fall lands outside the frame.
    task automatic spi_frame(input int nbytes, input int tail_bits);
        logic       is_read;
        logic [7:0] rx;
        logic       mi;
        logic       oe;
        logic       exp_oe;
        int         nb;
        int         tot;
        is_read = ~tx_buf[0][7];
        rx  = 8'h00;
        tot = nbytes + ((tail_bits > 0) ? 1 : 0);
        @(posedge clk); #1;
        spi_csn = 1'b0;
        repeat (HALF) @(posedge clk);
        for (int b = 0; b < tot; b++) begin
            nb = (b < nbytes) ? 8 : tail_bits;
            for (int k = 0; k < nb; k++) begin
                spi_bit(tx_buf[b][7-k], mi, oe);
                rx = {rx[6:0], mi};
                if (k == 0) begin
                    exp_oe = (b > 0 && is_read) ? 1'b0 : 1'b1;
                    n_cmp++;
                    if (oe !== exp_oe) begin
                        n_err++;
                        $display("FAIL misooen: byte %0d got %b, expected %b", b, oe, exp_oe);
                    end
                end
            end
            if (nb == 8 && b > 0 && is_read) begin
                n_cmp++;
                if (rd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected: MISO byte %h, no read expected", rx);
                end else begin
                    logic [7:0] exp_b;
                    exp_b = rd_q.pop_front();
                    if (rx !== exp_b) begin
                        n_err++;
                        $display("FAIL rd_data: MISO byte %h, expected %h", rx, exp_b);
                    end else begin
                        $display("read byte=%h", rx);
                    end
                end
            end
        end
        repeat (HALF) @(posedge clk);
        spi_csn = 1'b1;
        repeat (HALF) @(posedge clk);
        spi_sck = 1'b0;
        repeat (2*HALF) @(posedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        spi_csn = 1'b1;
        spi_sck = 1'b0;
        spi_mosi = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({spi_miso, spi_misooen, wr_pulse, rd_pulse, frame_err} !== 5'b01000) begin
            n_err++;
            $display("FAIL reset_outs: miso/oen/wr/rd/fe=%b, expected 01000",
                     {spi_miso, spi_misooen, wr_pulse, rd_pulse, frame_err});
        end
        n_cmp++;
        if (wr_addr_o !== '0 || regs_o !== model_img()) begin
            n_err++;
            $display("FAIL reset_regs: wr_addr=%0d regs=%h, expected 0 / %h", wr_addr_o, regs_o, model_img());
        end
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (spi_misooen !== 1'b1 || frame_err !== 1'b0 || regs_o !== model_img()) begin
            n_err++;
            $display("FAIL reset_idle: oen=%b fe=%b regs=%h, expected 1 0 %h",
                     spi_misooen, frame_err, regs_o, model_img());
        end
        $display("reset done");
    endtask

    task automatic test_write();
        tx_buf[0] = 8'h83; tx_buf[1] = 8'h5C;
        push_write(4'd3, 8'h5C);
        spi_frame(2, 0);
        n_cmp++;
        if (wr_q.size() != 0 || regs_o[31:24] !== 8'h5C) begin
            n_err++;
            $display("FAIL write_single: pending=%0d reg3=%h, expected 0 pending and 5c", wr_q.size(), regs_o[31:24]);
        end
    endtask

    task automatic test_burst_wrap();
        tx_buf[0] = 8'h8F; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
        push_write(4'd15, 8'h11);
        push_write(4'd0,  8'h22);
        push_write(4'd1,  8'h33);
        spi_frame(4, 0);
        n_cmp++;
        if (wr_q.size() != 0 || regs_o[7:0] !== 8'hA5 || regs_o[15:8] !== 8'h33 || regs_o[127:120] !== 8'h11) begin
            n_err++;
            $display("FAIL burst_wrap: pending=%0d reg0=%h reg1=%h reg15=%h, expected 0 a5 33 11",
                     wr_q.size(), regs_o[7:0], regs_o[15:8], regs_o[127:120]);
        end
    endtask

    task automatic test_read_id();
        int rd0;
        rd0 = rd_cnt;
        tx_buf[0] = 8'h00; tx_buf[1] = 8'hFF;
        rd_q.push_back(8'hA5);
        spi_frame(2, 0);
        n_cmp++;
        if (rd_cnt - rd0 != 1 || rd_q.size() != 0 || spi_misooen !== 1'b1) begin
            n_err++;
            $display("FAIL read_id: rd_pulses=%0d pending=%0d oen=%b, expected 1 0 1",
                     rd_cnt - rd0, rd_q.size(), spi_misooen);
        end
    endtask

    task automatic test_burst_read();
        int rd0;
        tx_buf[0] = 8'h82; tx_buf[1] = 8'hC3; tx_buf[2] = 8'h3C;
        push_write(4'd2, 8'hC3);
        push_write(4'd3, 8'h3C);
        spi_frame(3, 0);
        rd0 = rd_cnt;
        tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        rd_q.push_back(8'hC3);
        rd_q.push_back(8'h3C);
        spi_frame(3, 0);
        n_cmp++;
        if (rd_cnt - rd0 != 2 || rd_q.size() != 0 || wr_q.size() != 0) begin
            n_err++;
            $display("FAIL burst_read: rd_pulses=%0d rd_pending=%0d wr_pending=%0d, expected 2 0 0",
                     rd_cnt - rd0, rd_q.size(), wr_q.size());
        end
    endtask

    task automatic test_abort();
        int fe0;
        fe0 = fe_cnt;
        tx_buf[0] = 8'h84; tx_buf[1] = 8'hFF;
        spi_frame(1, 5);
        n_cmp++;
        if (fe_cnt - fe0 != 1 || regs_o[39:32] !== 8'h00) begin
            n_err++;
            $display("FAIL abort: frame_err=%0d reg4=%h, expected 1 and 00", fe_cnt - fe0, regs_o[39:32]);
        end
        tx_buf[0] = 8'h84; tx_buf[1] = 8'h42;
        push_write(4'd4, 8'h42);
        spi_frame(2, 0);
        n_cmp++;
        if (fe_cnt - fe0 != 1 || regs_o[39:32] !== 8'h42 || wr_q.size() != 0) begin
            n_err++;
            $display("FAIL after_abort: frame_err=%0d reg4=%h pending=%0d, expected 1 42 0",
                     fe_cnt - fe0, regs_o[39:32], wr_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic       mi;
        logic       oe;
        logic [7:0] cmd;
        int         fe0;
        int         rd0;
        cmd = 8'h86;
        @(posedge clk); #1;
        spi_csn = 1'b0;
        repeat (HALF) @(posedge clk);
        for (int k = 0; k < 8; k++) spi_bit(cmd[7-k], mi, oe);
        for (int k = 0; k < 4; k++) spi_bit(1'b1, mi, oe);
        rstn = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({spi_miso, spi_misooen, wr_pulse, rd_pulse, frame_err} !== 5'b01000 || wr_addr_o !== '0) begin
            n_err++;
            $display("FAIL midreset_outs: miso/oen/wr/rd/fe=%b wr_addr=%0d, expected 01000 0",
                     {spi_miso, spi_misooen, wr_pulse, rd_pulse, frame_err}, wr_addr_o);
        end
        n_cmp++;
        if (regs_o !== model_img()) begin
            n_err++;
            $display("FAIL midreset_regs: regs=%h, expected %h", regs_o, model_img());
        end
        spi_sck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        spi_csn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b1;
        fe0 = fe_cnt;
        repeat (10) @(posedge clk);
        rd0 = rd_cnt;
        tx_buf[0] = 8'h06; tx_buf[1] = 8'hFF;
        rd_q.push_back(8'h00);
        spi_frame(2, 0);
        n_cmp++;
        if (rd_cnt - rd0 != 1 || fe_cnt != fe0 || rd_q.size() != 0) begin
            n_err++;
            $display("FAIL midreset_read: rd_pulses=%0d frame_err=%0d pending=%0d, expected 1 0 0",
                     rd_cnt - rd0, fe_cnt - fe0, rd_q.size());
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rd_cnt = 0;
        fe_cnt = 0;
        test_reset();
        test_write();
        test_burst_wrap();
        test_read_id();
        test_burst_read();
        test_abort();
        test_reset_mid_frame();
        n_cmp++;
        if (wr_q.size() != 0 || rd_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: wr_pending=%0d rd_pending=%0d, expected 0 0", wr_q.size(), rd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
